switch_update_controller: RTL

Parametrised replacement for the per-switch synchroniser, debouncer and update-OR logic in the top level. It conditions NUM_CH asynchronous switch inputs and raises a power-up event once the clock is locked. It issues a held update request with a latched resolution snapshot, which stays stable until the render and port controllers acknowledge it. Events arriving during an outstanding request or holdoff are coalesced into exactly one follow-up request.

---
 rtl/switch_update_pkg.sv | 22 ++
 rtl/debounce_channel.sv | 60 ++++++
 rtl/switch_update_controller.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/switch_update_pkg.sv
// Shared types, width helpers and default timing for switch_update_controller.
package switch_update_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        HOLDOFF
    } upd_state_t;

    // Default timing: 10 ms debounce at 50 MHz.
    localparam int unsigned DEF_NUM_CH          = 4;
    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned DEF_PWRUP_DELAY     = 16;
    localparam int unsigned DEF_HOLDOFF_CYCLES  = 1024;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: multi-stage synchroniser, debounce counter and accept pulse.
module debounce_channel
    import switch_update_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sw_async,
    output logic o_sw_state,
    output logic o_sw_changed
);

    localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_state;
    logic                   r_changed;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Shift the raw pin through the synchroniser chain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sw_async};
        end
    end

    // Accept a new level only after it differs for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_state   <= 1'b0;
            r_changed <= 1'b0;
        end else begin
            r_changed <= 1'b0;
            if (w_sync != r_state) begin
                if (r_cnt == CNT_LAST) begin
                    r_state   <= w_sync;
                    r_changed <= 1'b1;
                    r_cnt     <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_sw_state   = r_state;
    assign o_sw_changed = r_changed;

endmodule

// File: rtl/switch_update_controller.sv
// Switch conditioning, power-up event and coalescing update-request handshake.
// Optional request counter on o_update_count enabled by `define SWITCH_UPDATE_COUNT_EN.
module switch_update_controller
    import switch_update_pkg::*;
#(
    parameter int unsigned NUM_CH          = DEF_NUM_CH,
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned PWRUP_DELAY     = DEF_PWRUP_DELAY,
    parameter int unsigned HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES
) (
    input  logic              i_clk,
    input  logic              i_sys_resetn,
    input  logic [NUM_CH-1:0] i_sw_async,
    input  logic              i_pll_locked,
    output logic [NUM_CH-1:0] o_sw_state,
    output logic [NUM_CH-1:0] o_sw_changed,
    output logic              o_update,
    input  logic              i_update_ack,
    output logic [NUM_CH-1:0] o_resolution,
    output logic              o_busy,
    output logic [7:0]        o_update_count
);

    localparam int unsigned   PW      = cnt_width(PWRUP_DELAY + 1);
    localparam logic [PW-1:0] PW_LAST = PW'(PWRUP_DELAY - 1);
    localparam int unsigned   HW      = cnt_width(HOLDOFF_CYCLES);
    localparam logic [HW-1:0] HO_LAST = HW'(HOLDOFF_CYCLES - 1);

    logic [NUM_CH-1:0] w_sw_state;
    logic [NUM_CH-1:0] w_sw_changed;
    logic [1:0]        r_lock_sync;
    logic [PW-1:0]     r_pwr_cnt;
    logic              r_pwr_armed;
    logic              r_pwrup_evt;
    upd_state_t        r_state;
    logic              r_update;
    logic              r_busy;
    logic              r_pending;
    logic [NUM_CH-1:0] r_resolution;
    logic [HW-1:0]     r_ho_cnt;
    logic              w_event;
    logic              w_ho_last;
    logic              w_req_issue;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .i_clk        (i_clk),
            .i_rst_n      (i_sys_resetn),
            .i_sw_async   (i_sw_async[g]),
            .o_sw_state   (w_sw_state[g]),
            .o_sw_changed (w_sw_changed[g])
        );
    end

    // Power-up event: lock must stay high PWRUP_DELAY cycles; fires once per reset.
    always_ff @(posedge i_clk or negedge i_sys_resetn) begin
        if (!i_sys_resetn) begin
            r_lock_sync <= 2'b00;
            r_pwr_cnt   <= '0;
            r_pwr_armed <= 1'b1;
            r_pwrup_evt <= 1'b0;
        end else begin
            r_lock_sync <= {r_lock_sync[0], i_pll_locked};
            r_pwrup_evt <= 1'b0;
            if (!r_lock_sync[1]) begin
                r_pwr_cnt <= '0;
            end else if (r_pwr_armed) begin
                if (r_pwr_cnt == PW_LAST) begin
                    r_pwrup_evt <= 1'b1;
                    r_pwr_armed <= 1'b0;
                end
                r_pwr_cnt <= r_pwr_cnt + PW'(1);
            end
        end
    end

    assign w_event   = r_pwrup_evt | (|w_sw_changed);
    assign w_ho_last = (r_ho_cnt == HO_LAST);
    // An event landing on the final holdoff cycle still counts as pending.
    assign w_req_issue = ((r_state == IDLE) && w_event) ||
                         ((r_state == HOLDOFF) && w_ho_last && (r_pending || w_event));

    // Request handshake FSM with registered update/busy/resolution.
    always_ff @(posedge i_clk or negedge i_sys_resetn) begin
        if (!i_sys_resetn) begin
            r_state      <= IDLE;
            r_update     <= 1'b0;
            r_busy       <= 1'b0;
            r_pending    <= 1'b0;
            r_resolution <= '0;
            r_ho_cnt     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_issue) begin
                        r_state      <= PENDING;
                        r_update     <= 1'b1;
                        r_busy       <= 1'b1;
                        r_resolution <= w_sw_state;
                    end
                end
                PENDING: begin
                    if (w_event) begin
                        r_pending <= 1'b1;
                    end
                    if (i_update_ack) begin
                        r_state  <= HOLDOFF;
                        r_update <= 1'b0;
                        r_ho_cnt <= '0;
                    end
                end
                HOLDOFF: begin
                    if (w_event) begin
                        r_pending <= 1'b1;
                    end
                    if (w_ho_last) begin
                        if (w_req_issue) begin
                            r_state      <= PENDING;
                            r_update     <= 1'b1;
                            r_resolution <= w_sw_state;
                            r_pending    <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_ho_cnt <= r_ho_cnt + HW'(1);
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_update <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

`ifdef SWITCH_UPDATE_COUNT_EN
    logic [7:0] r_update_count;

    // Count issued requests, wrapping naturally at 8 bits.
    always_ff @(posedge i_clk or negedge i_sys_resetn) begin
        if (!i_sys_resetn) begin
            r_update_count <= 8'd0;
        end else if (w_req_issue) begin
            r_update_count <= r_update_count + 8'd1;
        end
    end

    assign o_update_count = r_update_count;
`else
    assign o_update_count = 8'd0;
`endif

    assign o_sw_state   = w_sw_state;
    assign o_sw_changed = w_sw_changed;
    assign o_update     = r_update;
    assign o_resolution = r_resolution;
    assign o_busy       = r_busy;

endmodule
